riscv_writeback_unit: RTL and testbench
=======================================

Name: riscv_writeback_unit

Overview:
- Result side of the execute datapath. Operand selection feeds the ALU; this block collects what comes out of it.
- Accepts one retiring instruction per handshake from execute and selects its writeback source: ALU result, load data, PC+4 or CSR.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the data.
- Drives the register-file write port and the forwarding bus from registered outputs.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- LOAD_TIMEOUT, 64, maximum WAIT_MEM cycles; used only with RISCV_WB_LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  writeback can accept
- wb_src  in  2  WB_SRC_ALU / WB_SRC_MEM / WB_SRC_PC_NEXT / WB_SRC_CSR
- rd_we  in  1  instruction writes rd
- rd_addr  in  5  destination register
- alu_result  in  32  ALU output; also the load address
- pc_value  in  32  instruction PC
- csr_value  in  32  CSR read data
- load_funct3  in  3  load size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word, word-aligned
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- load_fault  out  1  one-cycle pulse on misaligned, illegal-funct3 or timed-out load
- busy  out  1  state is WAIT_MEM

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; all registered outputs rf_we, rf_waddr, rf_wdata and load_fault are 0.
  - Any load in flight is abandoned; a later mem_rvalid is ignored.
- States:
  - IDLE: ex_ready=1.
  - WAIT_MEM: ex_ready=0, busy=1.
- Handshake:
  - Transfer occurs when ex_valid && ex_ready.
  - Inputs are sampled only on a transfer.
  - ex_valid without a transfer has no effect.
- Non-load transfer (wb_src != WB_SRC_MEM):
  - Next cycle: rf_we = rd_we && rd_addr!=0; rf_waddr=rd_addr.
  - rf_wdata = alu_result, pc_value+4 (mod 2^32), or csr_value.
  - Latency 1; back-to-back transfers give one write per cycle.
- Load transfer:
  - Latch rd_addr, rd_we, load_funct3 and alu_result[1:0]; go to WAIT_MEM.
  - mem_rvalid is honoured only in WAIT_MEM, never in the transfer cycle.
  - On mem_rvalid: select byte lane addr[1:0] or half-word lane addr[1]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - The write appears one cycle later (rf_we as above); state returns to IDLE in the same edge.
  - Minimum load latency is 2 cycles after transfer.
  - ex_ready returns high the cycle after mem_rvalid.
- Faults (no register write, load_fault pulse):
  - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, flagged at transfer.
  - The load still enters WAIT_MEM so the memory response is consumed.
  - The fault pulses in the cycle the write would have occurred.
  - load_funct3 011, 110 or 111: same treatment.
- rd_addr=0 or rd_we=0: rf_we stays 0; rf_waddr and rf_wdata still update.
- rf_we is a single-cycle pulse per instruction; outputs hold their data between writes.
- mem_rvalid in IDLE is ignored, with no effect on state.

Optional Feature:
- RISCV_WB_LOAD_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_rvalid.
  - When it reaches LOAD_TIMEOUT: return to IDLE, pulse load_fault next cycle, no write.
  - mem_rvalid in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; WAIT_MEM waits indefinitely.

Decomposition:
- Shared package (alongside the ALU_SRC_* constants):
  - WB_SRC_* 2-bit enum.
  - LOAD_* funct3 constants.
  - wb_state_t (IDLE, WAIT_MEM).
- Sub-module riscv_load_align: combinational, inputs rdata, addr[1:0] and funct3; outputs aligned data and a misalign/illegal flag.
- FSM, handshake and output registers stay in riscv_writeback_unit.

Test Plan:
- ALU write: wb_src=ALU, rd=5, alu_result=0xDEADBEEF → next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; ex_ready stays 1.
- PC+4 with wrap: wb_src=PC_NEXT, pc=0xFFFFFFFC, rd=1 → wdata=0x00000000. rd=0 with same stimulus → rf_we=0.
- Loads with mem_rdata=0x80F1827F:
  - LB addr[1:0]=0 → 0x0000007F.
  - LB addr=3 → 0xFFFFFF80.
  - LHU addr=2 → 0x000080F1.
  - LH addr=2 → 0xFFFF80F1.
  - mem_rvalid 3 cycles after transfer → ex_ready low 3 cycles, write on cycle 4.
- Misaligned LW at addr=0x1002 → WAIT_MEM, response consumed, load_fault pulse, rf_we=0. Stray mem_rvalid in IDLE → no write.
- Reset mid-load: rst_n low during WAIT_MEM, then mem_rvalid after release → IDLE, ex_ready=1, no write.
- With RISCV_WB_LOAD_TIMEOUT_EN and LOAD_TIMEOUT=4, no response → load_fault after 4 WAIT_MEM cycles, return to IDLE.

Source files
------------

// File: rtl/riscv_writeback_unit_pkg.sv
// Shared execute/writeback encodings: operand-select, writeback-source and load funct3 codes,
// plus the writeback FSM state type.
package riscv_writeback_unit_pkg;

  localparam logic [1:0] ALU_SRC_REG = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM = 2'd1;
  localparam logic [1:0] ALU_SRC_PC  = 2'd2;

  typedef enum logic [1:0] {
    WB_SRC_ALU     = 2'd0,
    WB_SRC_MEM     = 2'd1,
    WB_SRC_PC_NEXT = 2'd2,
    WB_SRC_CSR     = 2'd3
  } wb_src_t;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/riscv_writeback_unit_load_align.sv
// riscv_load_align: picks the byte/half lane out of a word-aligned load and extends it;
// flags misaligned halfword/word accesses and unsupported funct3 encodings.
module riscv_load_align
  import riscv_writeback_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data  = '0;
    o_fault = 1'b0;
    case (i_funct3)
      LOAD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LOAD_LBU: o_data = {24'd0, w_byte};
      LOAD_LH: begin
        o_data  = {{16{w_half[15]}}, w_half};
        o_fault = i_addr[0];
      end
      LOAD_LHU: begin
        o_data  = {16'd0, w_half};
        o_fault = i_addr[0];
      end
      LOAD_LW: begin
        o_data  = i_rdata;
        o_fault = |i_addr;
      end
      default:  o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_writeback_unit.sv
// riscv_writeback_unit: selects the writeback source, sequences loads through WAIT_MEM and
// drives registered RF write / forwarding outputs. Optional load timeout: RISCV_WB_LOAD_TIMEOUT_EN.
module riscv_writeback_unit
  import riscv_writeback_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      wb_src,
  input  logic            rd_we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_value,
  input  logic [XLEN-1:0] csr_value,
  input  logic [2:0]      load_funct3,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_fault,
  output logic            busy
);

  wb_state_t       r_state;
  logic [4:0]      r_ld_rd;
  logic            r_ld_we;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_addr;
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_load_fault;

  logic            w_xfer;
  logic [XLEN-1:0] w_src_data;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_fault;
  logic            w_timeout;

  assign ex_ready   = (r_state == IDLE);
  assign busy       = (r_state == WAIT_MEM);
  assign w_xfer     = ex_valid && ex_ready;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign load_fault = r_load_fault;

  always_comb begin
    w_src_data = alu_result;
    case (wb_src)
      WB_SRC_PC_NEXT: w_src_data = pc_value + XLEN'(4);
      WB_SRC_CSR:     w_src_data = csr_value;
      default:        w_src_data = alu_result;
    endcase
  end

  // Alignment check uses the latched address/funct3, so the fault decision made from the
  // transfer-time values is simply carried through WAIT_MEM to the completion edge.
  riscv_load_align u_align (
    .i_rdata  (mem_rdata),
    .i_addr   (r_ld_addr),
    .i_funct3 (r_ld_funct3),
    .o_data   (w_ld_data),
    .o_fault  (w_ld_fault)
  );

`ifdef RISCV_WB_LOAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Fires on the WAIT_MEM cycle whose increment would make the count reach LOAD_TIMEOUT.
  assign w_timeout = busy && !mem_rvalid && (r_tmo_cnt == TMO_W'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo_cnt <= '0;
    else if (w_xfer)
      r_tmo_cnt <= '0;
    else if (busy && !mem_rvalid)
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^LOAD_TIMEOUT;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ld_rd      <= '0;
      r_ld_we      <= 1'b0;
      r_ld_funct3  <= '0;
      r_ld_addr    <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_load_fault <= 1'b0;
    end else begin
      r_rf_we      <= 1'b0;
      r_load_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (wb_src == WB_SRC_MEM) begin
              r_ld_rd     <= rd_addr;
              r_ld_we     <= rd_we;
              r_ld_funct3 <= load_funct3;
              r_ld_addr   <= alu_result[1:0];
              r_state     <= WAIT_MEM;
            end else begin
              r_rf_we    <= rd_we && (rd_addr != 5'd0);
              r_rf_waddr <= rd_addr;
              r_rf_wdata <= w_src_data;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
            if (w_ld_fault) begin
              r_load_fault <= 1'b1;
            end else begin
              r_rf_we    <= r_ld_we && (r_ld_rd != 5'd0);
              r_rf_waddr <= r_ld_rd;
              r_rf_wdata <= w_ld_data;
            end
          end else if (w_timeout) begin
            r_state      <= IDLE;
            r_load_fault <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_writeback_unit.sv
// Directed bench for riscv_writeback_unit: ALU/PC+4/CSR writes, aligned loads, faults,
// reset mid-load and (when RISCV_WB_LOAD_TIMEOUT_EN is defined) the load timeout.
module tb_riscv_writeback_unit;
  import riscv_writeback_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  wb_src = 2'd0;
  logic        rd_we = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] pc_value = 32'd0;
  logic [31:0] csr_value = 32'd0;
  logic [2:0]  load_funct3 = 3'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_fault;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  riscv_writeback_unit #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wb_src(wb_src), .rd_we(rd_we), .rd_addr(rd_addr), .alu_result(alu_result),
    .pc_value(pc_value), .csr_value(csr_value), .load_funct3(load_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .load_fault(load_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || load_fault !== 1'b0)
      $display("FAIL reset_outputs got we=%b waddr=%0d wdata=%h fault=%b want 0/0/0/0",
               rf_we, rf_waddr, rf_wdata, load_fault);
    else n_pass++;
    n_chk++;
    if (ex_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_state got ready=%b busy=%b want 1/0", ex_ready, busy);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1'b1; wb_src = WB_SRC_ALU; rd_we = 1'b1; rd_addr = 5'd5;
    alu_result = 32'hDEADBEEF;
    step();
    ex_valid = 1'b0;
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || ex_ready !== 1'b1)
      $display("FAIL alu_write got we=%b waddr=%0d wdata=%h ready=%b want 1/5/deadbeef/1",
               rf_we, rf_waddr, rf_wdata, ex_ready);
    else n_pass++;
    step();
    n_chk++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'hDEADBEEF)
      $display("FAIL alu_pulse_hold got we=%b wdata=%h want 0/deadbeef", rf_we, rf_wdata);
    else n_pass++;
  endtask

  task automatic test_pc_next();
    ex_valid = 1'b1; wb_src = WB_SRC_PC_NEXT; rd_we = 1'b1; rd_addr = 5'd1;
    pc_value = 32'hFFFFFFFC;
    step();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h00000000)
      $display("FAIL pc4_wrap got we=%b waddr=%0d wdata=%h want 1/1/00000000",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    rd_addr = 5'd0; pc_value = 32'h00001000;
    step();
    ex_valid = 1'b0;
    n_chk++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h00001004)
      $display("FAIL pc4_rd0 got we=%b waddr=%0d wdata=%h want 0/0/00001004",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; wb_src = WB_SRC_CSR; rd_we = 1'b1; rd_addr = 5'd7;
    csr_value = 32'h12345678;
    step();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h12345678)
      $display("FAIL b2b_csr got we=%b waddr=%0d wdata=%h want 1/7/12345678",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    wb_src = WB_SRC_ALU; rd_we = 1'b0; rd_addr = 5'd9; alu_result = 32'hA5A5A5A5;
    step();
    n_chk++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA5A5A5A5)
      $display("FAIL b2b_rdwe0 got we=%b waddr=%0d wdata=%h want 0/9/a5a5a5a5",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    rd_we = 1'b1; rd_addr = 5'd10; alu_result = 32'h0BADF00D;
    step();
    ex_valid = 1'b0;
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h0BADF00D)
      $display("FAIL b2b_alu got we=%b waddr=%0d wdata=%h want 1/10/0badf00d",
               rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    step();
  endtask

  // Transfer a load, present the response `dly` cycles after the transfer, check the result.
  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input int dly, input logic exp_fault, input logic [31:0] exp_data);
    int lowc;
    lowc = 0;
    ex_valid = 1'b1; wb_src = WB_SRC_MEM; rd_we = 1'b1; rd_addr = 5'd12;
    alu_result = addr; load_funct3 = f3; mem_rdata = 32'h80F1827F;
    mem_rvalid = 1'b1;  // must be ignored in the transfer cycle
    step();
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    for (int i = 1; i < dly; i++) begin
      if (!ex_ready && !rf_we) lowc++;
      step();
    end
    if (!ex_ready && !rf_we) lowc++;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    n_chk++;
    if (lowc !== dly)
      $display("FAIL %s_stall got %0d want %0d", name, lowc, dly);
    else n_pass++;
    n_chk++;
    if (exp_fault) begin
      if (rf_we !== 1'b0 || load_fault !== 1'b1 || ex_ready !== 1'b1)
        $display("FAIL %s_fault got we=%b fault=%b ready=%b want 0/1/1",
                 name, rf_we, load_fault, ex_ready);
      else n_pass++;
    end else begin
      if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== exp_data ||
          load_fault !== 1'b0 || ex_ready !== 1'b1)
        $display("FAIL %s got we=%b waddr=%0d wdata=%h fault=%b ready=%b want 1/12/%h/0/1",
                 name, rf_we, rf_waddr, rf_wdata, load_fault, ex_ready, exp_data);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_stray_rvalid();
    logic [31:0] held;
    held = rf_wdata;
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_rvalid = 1'b0;
    n_chk++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || load_fault !== 1'b0 || rf_wdata !== held)
      $display("FAIL stray_rvalid got we=%b busy=%b fault=%b wdata=%h want 0/0/0/%h",
               rf_we, busy, load_fault, rf_wdata, held);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    ex_valid = 1'b1; wb_src = WB_SRC_MEM; rd_we = 1'b1; rd_addr = 5'd3;
    alu_result = 32'h0; load_funct3 = LOAD_LW;
    step();
    ex_valid = 1'b0;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL midload_busy got %b want 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #2;
    n_chk++;
    if (busy !== 1'b0 || ex_ready !== 1'b1 || rf_wdata !== 32'd0)
      $display("FAIL midload_reset got busy=%b ready=%b wdata=%h want 0/1/0",
               busy, ex_ready, rf_wdata);
    else n_pass++;
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    n_chk++;
    if (rf_we !== 1'b0 || ex_ready !== 1'b1 || rf_wdata !== 32'd0)
      $display("FAIL midload_late_rvalid got we=%b ready=%b wdata=%h want 0/1/0",
               rf_we, ex_ready, rf_wdata);
    else n_pass++;
  endtask

`ifdef RISCV_WB_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int busyc;
    busyc = 0;
    ex_valid = 1'b1; wb_src = WB_SRC_MEM; rd_we = 1'b1; rd_addr = 5'd4;
    alu_result = 32'h0; load_funct3 = LOAD_LW;
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy && !load_fault) busyc++;
      step();
    end
    n_chk++;
    if (busyc !== 4) $display("FAIL timeout_wait got %0d want 4", busyc);
    else n_pass++;
    n_chk++;
    if (load_fault !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0)
      $display("FAIL timeout_fault got fault=%b busy=%b we=%b want 1/0/0",
               load_fault, busy, rf_we);
    else n_pass++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_pc_next();
    test_back_to_back();
    test_load("lb0",  LOAD_LB,  32'h0000_1000, 1, 1'b0, 32'h0000007F);
    test_load("lb3",  LOAD_LB,  32'h0000_1003, 1, 1'b0, 32'hFFFFFF80);
    test_load("lbu1", LOAD_LBU, 32'h0000_1001, 2, 1'b0, 32'h00000082);
    test_load("lhu2", LOAD_LHU, 32'h0000_1002, 1, 1'b0, 32'h000080F1);
    test_load("lh2",  LOAD_LH,  32'h0000_1002, 3, 1'b0, 32'hFFFF80F1);
    test_load("lh0",  LOAD_LH,  32'h0000_1000, 1, 1'b0, 32'hFFFF827F);
    test_load("lw0",  LOAD_LW,  32'h0000_1000, 1, 1'b0, 32'h80F1827F);
    test_load("lw_mis", LOAD_LW, 32'h0000_1002, 2, 1'b1, 32'h0);
    test_load("lh_mis", LOAD_LH, 32'h0000_1001, 1, 1'b1, 32'h0);
    test_load("ill_f3", 3'b011,  32'h0000_1000, 1, 1'b1, 32'h0);
    test_stray_rvalid();
    test_reset_mid_load();
`ifdef RISCV_WB_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
